// File: rtl/irq_ack_dispatcher.sv
// Requester-side front end for the 27-input priority interrupt controller:
// latches request pulses, accepts decoded grants and drives a supervised one-hot acknowledge.
module irq_ack_dispatcher #(
    parameter int NCH     = 9,
    parameter int NBUS    = 3,
    parameter int CW      = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NBUS*NCH-1:0]  req_in,
    output logic [NBUS*NCH-1:0]  pend,
    input  logic                 grant_valid,
    input  logic [NBUS-1:0]      grant_bus,
    input  logic [CW-1:0]        grant_chan,
    output logic                 grant_ready,
    output logic [NBUS*NCH-1:0]  ack,
    input  logic                 ack_taken,
    output logic                 err,
    output logic                 tmo,
    output logic                 busy
);
    localparam int NREQ  = NBUS * NCH;
    localparam int IW    = $clog2(NREQ);
    localparam int CNT_W = 8;

    typedef enum logic [1:0] {IDLE, ACK, RECOVER} state_t;

    state_t            state_q;
    logic [NREQ-1:0]   pend_q, pend_d, clr;
    logic [NREQ-1:0]   ack_q;
    logic [IW-1:0]     idx_q, idx_dec;
    logic [CNT_W-1:0]  cnt_q;
    logic              grant_ready_q, busy_q, err_q, tmo_q;
    logic              bus_found, chan_ok, legal, accept;
    int                bus_int, idx_int;

    function automatic logic [NREQ-1:0] onehot(input logic [IW-1:0] i);
        return NREQ'(1) << i;
    endfunction

    // Grant decode: lowest-index bus flag wins, then bus*NCH + channel.
    always_comb begin
        bus_found = 1'b0;
        bus_int   = 0;
        for (int b = NBUS - 1; b >= 0; b--) begin
            if (grant_bus[b]) begin
                bus_found = 1'b1;
                bus_int   = b;
            end
        end
        chan_ok = (int'(grant_chan) < NCH);
        idx_int = bus_int * NCH + int'(grant_chan);
        idx_dec = IW'(idx_int);
        legal   = bus_found && chan_ok && pend_q[idx_dec];
        accept  = (state_q == IDLE) && grant_valid && legal;
    end

    // A request arriving in the clearing cycle survives: set is applied after clear.
    always_comb begin
        clr    = (state_q == ACK && ack_taken) ? onehot(idx_q) : '0;
        pend_d = (pend_q & ~clr) | req_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pend_q <= '0;
        else        pend_q <= pend_d;
    end

    // Index and countdown carry no reset: they are only read while in ACK.
    always_ff @(posedge clk) begin
        if (accept) begin
            idx_q <= idx_dec;
            cnt_q <= CNT_W'(TIMEOUT);
        end else if (state_q == ACK) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            ack_q         <= '0;
            grant_ready_q <= 1'b1;
            busy_q        <= 1'b0;
            err_q         <= 1'b0;
            tmo_q         <= 1'b0;
        end else begin
            err_q <= 1'b0;
            tmo_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_valid) begin
                        if (legal) begin
                            state_q       <= ACK;
                            ack_q         <= onehot(idx_dec);
                            grant_ready_q <= 1'b0;
                            busy_q        <= 1'b1;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                ACK: begin
                    if (ack_taken || cnt_q == CNT_W'(1)) begin
                        state_q <= RECOVER;
                        ack_q   <= '0;
                        tmo_q   <= !ack_taken;
                    end
                end
                RECOVER: begin
                    state_q       <= IDLE;
                    grant_ready_q <= 1'b1;
                    busy_q        <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign pend        = pend_q;
    assign ack         = ack_q;
    assign grant_ready = grant_ready_q;
    assign busy        = busy_q;
    assign err         = err_q;
    assign tmo         = tmo_q;
endmodule

// File: tb/tb_irq_ack_dispatcher.sv
// Randomized bench for irq_ack_dispatcher, checked against a transaction-level
// model of pending bits and acknowledge timing.
module tb_irq_ack_dispatcher;
    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [26:0] req_in = '0;
    logic [26:0] pend;
    logic        grant_valid = 1'b0;
    logic [2:0]  grant_bus = '0;
    logic [3:0]  grant_chan = '0;
    logic        grant_ready;
    logic [26:0] ack;
    logic        ack_taken = 1'b0;
    logic        err, tmo, busy;

    int          n_chk = 0;
    int          n_fail = 0;
    logic [26:0] mpend = '0;
    bit          noise = 1'b0;

    irq_ack_dispatcher #(.NCH(9), .NBUS(3), .CW(4), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .req_in(req_in), .pend(pend),
        .grant_valid(grant_valid), .grant_bus(grant_bus), .grant_chan(grant_chan),
        .grant_ready(grant_ready), .ack(ack), .ack_taken(ack_taken),
        .err(err), .tmo(tmo), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [26:0] rand_req();
        logic [31:0] r;
        r = $urandom & $urandom & $urandom & $urandom;
        return noise ? r[26:0] : 27'd0;
    endfunction

    // One clock edge; the model applies clear-then-set like the pending rules say.
    task automatic tick(input logic [26:0] req, input logic [26:0] clr_exp);
        req_in = req;
        @(posedge clk);
        #1;
        mpend  = (mpend & ~clr_exp) | req;
        req_in = '0;
        chk("pend", pend, mpend);
    endtask

    // Issue one grant; take_at = ACK cycle index in which ack_taken is raised (>= TMO: never).
    task automatic do_grant(input logic [2:0] gb, input logic [3:0] gc, input int take_at,
                            input logic [26:0] req_at_take);
        int          b;
        int          idx;
        logic        legal;
        logic        taken;
        logic [26:0] oh;
        b = -1;
        for (int i = 2; i >= 0; i--) if (gb[i]) b = i;
        idx   = (b < 0) ? 0 : b * 9 + int'(gc);
        legal = (b >= 0) && (gc < 4'd9) && mpend[idx];
        oh    = legal ? (27'd1 << idx) : 27'd0;
        chk("ready_idle", grant_ready, 1'b1);
        grant_valid = 1'b1;
        grant_bus   = gb;
        grant_chan  = gc;
        tick(rand_req(), '0);
        grant_valid = 1'b0;
        grant_bus   = 3'($urandom);
        grant_chan  = 4'($urandom);
        chk("err", err, !legal);
        if (!legal) begin
            chk("ack_illegal", ack, 0);
            chk("busy_illegal", busy, 1'b0);
            tick(rand_req(), '0);
            chk("err_drop", err, 1'b0);
            chk("ready_after_err", grant_ready, 1'b1);
            return;
        end
        taken = 1'b0;
        for (int c = 0; c < TMO && !taken; c++) begin
            chk("ack_on", ack, oh);
            chk("busy_on", busy, 1'b1);
            chk("ready_off", grant_ready, 1'b0);
            chk("tmo_quiet", tmo, 1'b0);
            if (c == take_at) begin
                ack_taken = 1'b1;
                tick(req_at_take, oh);
                ack_taken = 1'b0;
                taken = 1'b1;
            end else begin
                tick(rand_req(), '0);
            end
        end
        chk("ack_off", ack, 0);
        chk("tmo", tmo, !taken);
        chk("ready_recover", grant_ready, 1'b0);
        chk("busy_recover", busy, 1'b1);
        ack_taken = 1'($urandom);
        tick(rand_req(), '0);
        ack_taken = 1'b0;
        chk("ready_back", grant_ready, 1'b1);
        chk("busy_back", busy, 1'b0);
        chk("tmo_drop", tmo, 1'b0);
    endtask

    initial begin
        logic [2:0] gb;
        logic [3:0] gc;
        int         idx;
        int         b;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_pend", pend, 0);
        chk("rst_ack", ack, 0);
        chk("rst_err", err, 1'b0);
        chk("rst_tmo", tmo, 1'b0);
        chk("rst_busy", busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_ready", grant_ready, 1'b1);

        tick(27'd1 << 13, '0);
        do_grant(3'b010, 4'd4, 1, '0);
        chk("basic_cleared", pend[13], 1'b0);

        tick((27'd1 << 2) | (27'd1 << 11), '0);
        do_grant(3'b111, 4'd2, 0, '0);
        chk("prio_keep11", pend[11], 1'b1);
        chk("prio_clear2", pend[2], 1'b0);

        do_grant(3'b001, 4'd9, 0, '0);
        do_grant(3'b000, 4'd3, 0, '0);
        do_grant(3'b100, 4'd5, 0, '0);

        tick(27'd1 << 7, '0);
        do_grant(3'b001, 4'd7, TMO, '0);
        chk("tmo_keep7", pend[7], 1'b1);
        do_grant(3'b001, 4'd7, TMO - 1, '0);

        tick(27'd1 << 20, '0);
        do_grant(3'b100, 4'd2, 1, 27'd1 << 20);
        chk("collide_keep20", pend[20], 1'b1);

        tick(27'd1 << 24, '0);
        grant_valid = 1'b1;
        grant_bus   = 3'b100;
        grant_chan  = 4'd6;
        tick('0, '0);
        grant_valid = 1'b0;
        chk("pre_rst_ack", ack, 27'd1 << 24);
        #2;
        rst_n = 1'b0;
        #1;
        mpend = '0;
        chk("arst_ack", ack, 0);
        chk("arst_pend", pend, 0);
        chk("arst_busy", busy, 1'b0);
        chk("arst_tmo", tmo, 1'b0);
        chk("arst_err", err, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(27'd1 << 5, '0);
        do_grant(3'b001, 4'd5, 2, '0);

        noise = 1'b1;
        for (int t = 0; t < 60; t++) begin
            repeat ($urandom_range(0, 3)) tick(rand_req(), '0);
            if ($urandom_range(0, 3) != 0 && mpend != '0) begin
                idx = $urandom_range(0, 26);
                while (!mpend[idx]) idx = (idx + 1) % 27;
                b  = idx / 9;
                gc = 4'(idx % 9);
                gb = 3'(1 << b) | (3'($urandom) & (3'b111 << (b + 1)));
            end else begin
                gb = 3'($urandom_range(0, 7));
                gc = 4'($urandom_range(0, 11));
            end
            do_grant(gb, gc, $urandom_range(0, TMO + 1), rand_req());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
